sccb_cfg_sequencer: RTL
=======================

Name: sccb_cfg_sequencer

Overview:
- Sequences the SCCB camera-control core through a camera register-initialisation table stored in an external ROM/BRAM.
- Also shares the SCCB core with single register writes from the APB host, using a fixed-priority, between-transaction arbitration scheme.
- Sits between the APB register block, the init table and the SCCB controller.
- Reports progress, completion and NACK errors to software.

Parameters:
- ADDR_W, 8, table address width (max 2^ADDR_W entries).
- DEV_ID, 8'h42, SCCB write device ID driven on every transaction.
- DELAY_UNIT, 50000, PCLK cycles per delay tick (1 ms at 50 MHz).
- MAX_RETRY, 2, re-issues allowed after a NACK before aborting.

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  synchronous active-high reset.
- cfg_start  in  1  one-cycle pulse; starts the table sequence from entry 0.
- cfg_busy  out  1  high while the sequence is running.
- cfg_done  out  1  one-cycle pulse at normal end of table.
- cfg_err  out  1  sticky NACK-abort flag; cleared by cfg_start or PRESET.
- cfg_count  out  ADDR_W  number of table writes ACKed in the current run.
- host_req  in  1  level; the host requests a single write; held until host_ack.
- host_reg  in  8  host register address; stable while host_req is high.
- host_wdata  in  8  host write data; stable while host_req is high.
- host_ack  out  1  one-cycle pulse when the host write completes.
- host_nack  out  1  valid with host_ack; 1 = final attempt NACKed.
- tbl_addr  out  ADDR_W  table read address.
- tbl_data  in  16  table entry {reg[15:8], data[7:0]}; 1-cycle read latency.
- sccb_start  out  1  one-cycle pulse; launches an SCCB 3-phase write.
- sccb_id  out  8  constant DEV_ID.
- sccb_reg  out  8  register address; held from sccb_start until sccb_done.
- sccb_wdata  out  8  write data; held from sccb_start until sccb_done.
- sccb_busy  in  1  SCCB core busy.
- sccb_done  in  1  one-cycle pulse at transaction end.
- sccb_nack  in  1  valid with sccb_done; 1 = slave NACK.

Behaviour:
- Clocking and reset: one clock (PCLK); reset (PRESET) is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; retry and delay counters 0.
- States: IDLE, FETCH, DECODE, ARB, ISSUE, WAIT, DELAY, HOST_ISSUE, HOST_WAIT.
- IDLE:
  - cfg_start -> clear cfg_err and cfg_count, tbl_addr=0, go to FETCH.
  - Otherwise, host_req -> HOST_ISSUE.
  - cfg_start wins if it coincides with host_req; the host is then served at the next ARB.
- FETCH: wait one cycle for tbl_data, then go to DECODE.
- DECODE, by entry type:
  - 16'hFFFF: end of table -> pulse cfg_done, go to IDLE.
  - reg==8'hFE: delay entry; load data*DELAY_UNIT into a 32-bit counter.
    - data==0 -> no delay; advance the address, go to FETCH.
    - Otherwise -> DELAY.
  - Any other entry -> ARB.
- ARB:
  - host_req -> HOST_ISSUE. The table entry is held, and ARB is re-entered afterwards.
  - Else, if sccb_busy==0 -> ISSUE.
- ISSUE: pulse sccb_start with reg/data, go to WAIT.
- WAIT, on sccb_done:
  - ACK -> cfg_count+1, tbl_addr+1, go to FETCH.
  - NACK with retries < MAX_RETRY -> retry+1, go to ARB.
  - NACK otherwise -> set cfg_err, go to IDLE. No cfg_done is pulsed.
  - The retry counter clears on each new entry.
- DELAY: decrement each cycle; at 1 -> tbl_addr+1, go to FETCH. A delay does not increment cfg_count.
- HOST_ISSUE / HOST_WAIT:
  - Same retry rule as WAIT.
  - On final completion: pulse host_ack, with host_nack = last nack.
  - Then return to IDLE if no sequence is active, else to ARB.
  - The host is never preempted mid-transaction.
- tbl_addr wrap: if tbl_addr is at 2^ADDR_W-1 and advancing, treat the table as ended. Pulse cfg_done; do not wrap.
- cfg_busy is 1 in every state reached from cfg_start until cfg_done or cfg_err, including host service inside the sequence.
- cfg_start while cfg_busy: ignored.
- PRESET mid-transaction: go to IDLE immediately, outputs to reset values. The SCCB core is expected to be reset by the same PRESET.
- sccb_start is never asserted while sccb_busy==1, nor while a transaction is outstanding.

Test Plan:
- Table {1280, 1101, FFFF}, all ACK -> two sccb_start, with reg/data 12/80 then 11/01. Then cfg_done pulse, cfg_count=2, cfg_busy low the next cycle.
- Table {FE05, 1234, FFFF}, DELAY_UNIT=10 -> the first sccb_start occurs 50 cycles (+FETCH/DECODE overhead) after the delay decode. cfg_count=1.
- Entry 1234 NACKed 3 times, MAX_RETRY=2 -> exactly 3 sccb_start, cfg_err=1, no cfg_done, cfg_count=0, return to IDLE.
- host_req (reg 3A, data 04) asserted during table entry 0 WAIT:
  - Entry 0 completes, then the host write issues before entry 1.
  - host_ack pulses once with host_nack=0.
  - Table completes with cfg_count unchanged by the host write.
- PRESET asserted in WAIT and in DELAY -> next cycle all outputs 0, state IDLE. A following cfg_start restarts at tbl_addr=0.
- cfg_start pulsed while busy, and cfg_start coincident with host_req in IDLE -> the in-progress run is unaffected. The host write is serviced at the first ARB.

Source files
------------

// File: rtl/sccb_cfg_sequencer.sv
`default_nettype none
//============================================================================
// Module   : sccb_cfg_sequencer
// Purpose  : Walks a camera register-initialisation table held in an external
//            synchronous ROM/BRAM and feeds each entry to the SCCB write core.
//            Single register writes from the APB host share the same core.
//            Arbitration happens only between transactions, and the host has
//            fixed priority at each arbitration point.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   PCLK, PRESET           clock, synchronous active-high reset
//   cfg_start              pulse: run the table from entry 0
//   cfg_busy/done/err      sequence running / normal end pulse / sticky abort
//   cfg_count              table writes ACKed in the current run
//   host_req/reg/wdata     host single-write request (level, held to ack)
//   host_ack/nack          host write completion pulse and final NACK status
//   tbl_addr/tbl_data      table read port (1-cycle read latency)
//   sccb_start/id/reg/wdata  launch of one 3-phase SCCB write
//   sccb_busy/done/nack    SCCB core status
//============================================================================
module sccb_cfg_sequencer #(
    parameter int          ADDR_W     = 8,
    parameter logic [7:0]  DEV_ID     = 8'h42,
    parameter int          DELAY_UNIT = 50000,
    parameter int          MAX_RETRY  = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cfg_start,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] cfg_count,
    input  logic              host_req,
    input  logic [7:0]        host_reg,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic              host_nack,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              sccb_start,
    output logic [7:0]        sccb_id,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_wdata,
    input  logic              sccb_busy,
    input  logic              sccb_done,
    input  logic              sccb_nack
);

    localparam logic [31:0]       c_delay_unit = 32'(DELAY_UNIT);
    localparam logic [7:0]        c_max_retry  = 8'(MAX_RETRY);
    localparam logic [ADDR_W-1:0] c_addr_one   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_last_addr  = '1;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH      = 4'd1,
        S_DECODE     = 4'd2,
        S_ARB        = 4'd3,
        S_ISSUE      = 4'd4,
        S_WAIT       = 4'd5,
        S_DELAY      = 4'd6,
        S_HOST_ISSUE = 4'd7,
        S_HOST_WAIT  = 4'd8
    } state_t;

    state_t      r_state;
    logic [7:0]  r_ent_reg;
    logic [7:0]  r_ent_data;
    logic [7:0]  r_retry;
    logic [7:0]  r_host_retry;
    logic [31:0] r_delay;

    logic        w_host_pend;
    logic        w_tbl_end;
    logic        w_is_delay;
    logic        w_at_last;
    logic [31:0] w_delay_load;

    // The request is still high during the cycle host_ack is shown; masking
    // it there keeps one request from being served twice.
    assign w_host_pend  = host_req & ~host_ack;
    assign w_tbl_end    = (tbl_data == 16'hFFFF);
    assign w_is_delay   = (tbl_data[15:8] == 8'hFE);
    assign w_at_last    = (tbl_addr == c_last_addr);
    assign w_delay_load = 32'(tbl_data[7:0]) * c_delay_unit;

    assign sccb_id = DEV_ID;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state      <= S_IDLE;
            r_ent_reg    <= 8'd0;
            r_ent_data   <= 8'd0;
            r_retry      <= 8'd0;
            r_host_retry <= 8'd0;
            r_delay      <= 32'd0;
            cfg_busy     <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
            cfg_count    <= '0;
            host_ack     <= 1'b0;
            host_nack    <= 1'b0;
            tbl_addr     <= '0;
            sccb_start   <= 1'b0;
            sccb_reg     <= 8'd0;
            sccb_wdata   <= 8'd0;
        end else begin
            cfg_done   <= 1'b0;
            host_ack   <= 1'b0;
            host_nack  <= 1'b0;
            sccb_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // A start wins over a coincident host request; the host
                    // is picked up at the first arbitration point.
                    if (cfg_start) begin
                        cfg_err   <= 1'b0;
                        cfg_count <= '0;
                        tbl_addr  <= '0;
                        cfg_busy  <= 1'b1;
                        r_state   <= S_FETCH;
                    end else if (w_host_pend) begin
                        r_host_retry <= 8'd0;
                        r_state      <= S_HOST_ISSUE;
                    end
                end

                S_FETCH: r_state <= S_DECODE;

                S_DECODE: begin
                    if (w_tbl_end) begin
                        cfg_done <= 1'b1;
                        cfg_busy <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_is_delay) begin
                        r_delay <= w_delay_load;
                        if (tbl_data[7:0] == 8'd0) begin
                            // Running off the last address ends the table
                            // rather than wrapping back to entry 0.
                            if (w_at_last) begin
                                cfg_done <= 1'b1;
                                cfg_busy <= 1'b0;
                                r_state  <= S_IDLE;
                            end else begin
                                tbl_addr <= tbl_addr + c_addr_one;
                                r_state  <= S_FETCH;
                            end
                        end else begin
                            r_state <= S_DELAY;
                        end
                    end else begin
                        r_ent_reg  <= tbl_data[15:8];
                        r_ent_data <= tbl_data[7:0];
                        r_retry    <= 8'd0;
                        r_state    <= S_ARB;
                    end
                end

                S_ARB: begin
                    if (w_host_pend) begin
                        r_host_retry <= 8'd0;
                        r_state      <= S_HOST_ISSUE;
                    end else if (!sccb_busy) begin
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    sccb_start <= 1'b1;
                    sccb_reg   <= r_ent_reg;
                    sccb_wdata <= r_ent_data;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (sccb_done) begin
                        if (!sccb_nack) begin
                            cfg_count <= cfg_count + c_addr_one;
                            if (w_at_last) begin
                                cfg_done <= 1'b1;
                                cfg_busy <= 1'b0;
                                r_state  <= S_IDLE;
                            end else begin
                                tbl_addr <= tbl_addr + c_addr_one;
                                r_state  <= S_FETCH;
                            end
                        end else if (r_retry < c_max_retry) begin
                            r_retry <= r_retry + 8'd1;
                            r_state <= S_ARB;
                        end else begin
                            cfg_err  <= 1'b1;
                            cfg_busy <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end

                S_DELAY: begin
                    if (r_delay <= 32'd1) begin
                        if (w_at_last) begin
                            cfg_done <= 1'b1;
                            cfg_busy <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            tbl_addr <= tbl_addr + c_addr_one;
                            r_state  <= S_FETCH;
                        end
                    end else begin
                        r_delay <= r_delay - 32'd1;
                    end
                end

                S_HOST_ISSUE: begin
                    // Entered from IDLE without a busy check, so hold off
                    // here until the core is free.
                    if (!sccb_busy) begin
                        sccb_start <= 1'b1;
                        sccb_reg   <= host_reg;
                        sccb_wdata <= host_wdata;
                        r_state    <= S_HOST_WAIT;
                    end
                end

                S_HOST_WAIT: begin
                    if (sccb_done) begin
                        if (sccb_nack && (r_host_retry < c_max_retry)) begin
                            r_host_retry <= r_host_retry + 8'd1;
                            r_state      <= S_HOST_ISSUE;
                        end else begin
                            host_ack  <= 1'b1;
                            host_nack <= sccb_nack;
                            // Resume the table (the held entry re-arbitrates)
                            // or drop back to idle if no run is active.
                            r_state   <= cfg_busy ? S_ARB : S_IDLE;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
